// File: rtl/sample_serializer_pkg.sv
// rtl/sample_serializer_pkg.sv - shared state encoding and frame geometry for the sample serializer
package sample_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A mono sample is sent once in the left half and once in the right half.
  localparam int unsigned SLOTS_PER_SAMPLE = 2;

  function automatic int unsigned frame_slots(input int unsigned sample_width);
    return SLOTS_PER_SAMPLE * sample_width;
  endfunction

endpackage

// File: rtl/sample_serializer_bclk_divider.sv
// rtl/sample_serializer_bclk_divider.sv - bit clock divider with falling-edge strobe
module bclk_divider #(
  parameter int unsigned BCLK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic fall
);

  localparam int unsigned     DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] TERM = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             bclk_q;
  logic             bclk_d;
  logic             term;

  // Count half periods while running; held at zero with bclk low otherwise.
  always_comb begin
    term   = run && (div_q == TERM);
    div_d  = '0;
    bclk_d = 1'b0;
    if (run) begin
      div_d  = term ? '0 : div_q + DIV_W'(1);
      bclk_d = term ? ~bclk_q : bclk_q;
    end
  end

  dffr #(.W(DIV_W)) u_div  (.clk(clk), .reset(reset), .d(div_d),  .q(div_q));
  dffr #(.W(1))     u_bclk (.clk(clk), .reset(reset), .d(bclk_d), .q(bclk_q));

  assign bclk = bclk_q;
  // High in the cycle whose clock edge drives bclk from high to low.
  assign fall = term && bclk_q;

endmodule

// File: rtl/sample_serializer_flops.sv
// rtl/sample_serializer_flops.sv - flop primitives with asynchronous active-low reset
module dffr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain register cleared to zero while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule

module dffre #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register that loads only when en is high, cleared to zero while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sample_serializer.sv
// rtl/sample_serializer.sv - mono sample to left-justified two-channel serial stream
module sample_serializer
  import sample_serializer_pkg::*;
#(
  parameter int unsigned BCLK_HALF    = 4,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    generate_next,
  input  logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int unsigned      FRAME     = frame_slots(SAMPLE_WIDTH);
  localparam int unsigned      SLOT_W    = $clog2(FRAME);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME - 1);
  localparam logic [SLOT_W-1:0] HALF      = SLOT_W'(SAMPLE_WIDTH);

  logic                    state_q;
  state_t                  state_d;
  logic                    run;
  logic                    bclk_fall;
  logic                    frame_start;
  logic                    start;
  logic                    reload;
  logic                    stop;
  logic [SLOT_W-1:0]       slot_q;
  logic [SLOT_W-1:0]       slot_d;
  logic [SLOT_W-1:0]       pos;
  logic [SAMPLE_WIDTH-1:0] pending_q;
  logic [SAMPLE_WIDTH-1:0] pending_d;
  logic                    pending_en;
  logic [SAMPLE_WIDTH-1:0] active_q;
  logic [SAMPLE_WIDTH-1:0] active_d;
  logic                    fresh_q;
  logic                    fresh_d;
  logic                    gen_d;
  logic                    under_d;
  logic                    sdata_d;
  logic                    lrclk_d;

  assign run = (state_q == ST_RUN);

  bclk_divider #(.BCLK_HALF(BCLK_HALF)) u_bclk_divider (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bclk  (bclk),
    .fall  (bclk_fall)
  );

  // Next-state logic for the frame sequencer, sample buffering and registered outputs.
  always_comb begin
    frame_start = bclk_fall && (slot_q == LAST_SLOT);
    start       = !run && enable;
    reload      = frame_start && enable;
    stop        = frame_start && !enable;

    state_d = run ? ST_RUN : ST_IDLE;
    if (start) state_d = ST_RUN;
    if (stop)  state_d = ST_IDLE;

    slot_d = slot_q;
    if (!run)           slot_d = '0;
    else if (bclk_fall) slot_d = frame_start ? '0 : slot_q + SLOT_W'(1);

    // A strobe on the frame-start edge is kept for the following frame.
    fresh_d = fresh_q;
    if (start || frame_start) fresh_d = 1'b0;
    if (run && sample_ready)  fresh_d = 1'b1;

    pending_en = start || (run && sample_ready);
    pending_d  = start ? '0 : sample;

    // Each run starts from silence; on a missed sample the old value repeats.
    active_d = active_q;
    if (start)                  active_d = '0;
    else if (reload && fresh_q) active_d = pending_q;

    gen_d   = start || reload;
    under_d = reload && !fresh_q;

    pos     = (slot_d >= HALF) ? slot_d - HALF : slot_d;
    lrclk_d = (state_d == ST_RUN) && (slot_d >= HALF);
    sdata_d = 1'b0;
    if (state_d == ST_RUN) begin
      for (int i = 0; i < SAMPLE_WIDTH; i++) begin
        if (pos == SLOT_W'(i)) sdata_d = active_d[SAMPLE_WIDTH-1-i];
      end
    end
  end

  dffr  #(.W(1))            u_state   (.clk(clk), .reset(reset), .d(state_d),  .q(state_q));
  dffr  #(.W(SLOT_W))       u_slot    (.clk(clk), .reset(reset), .d(slot_d),   .q(slot_q));
  dffre #(.W(SAMPLE_WIDTH)) u_pending (.clk(clk), .reset(reset), .en(pending_en),
                                       .d(pending_d), .q(pending_q));
  dffr  #(.W(SAMPLE_WIDTH)) u_active  (.clk(clk), .reset(reset), .d(active_d), .q(active_q));
  dffr  #(.W(1))            u_fresh   (.clk(clk), .reset(reset), .d(fresh_d),  .q(fresh_q));
  dffr  #(.W(1))            u_gen     (.clk(clk), .reset(reset), .d(gen_d),    .q(generate_next));
  dffr  #(.W(1))            u_under   (.clk(clk), .reset(reset), .d(under_d),  .q(underrun));
  dffr  #(.W(1))            u_sdata   (.clk(clk), .reset(reset), .d(sdata_d),  .q(sdata));
  dffr  #(.W(1))            u_lrclk   (.clk(clk), .reset(reset), .d(lrclk_d),  .q(lrclk));

endmodule

// File: tb/tb_sample_serializer.sv
// tb/tb_sample_serializer.sv - self-checking bench for sample_serializer
module tb_sample_serializer;

  localparam int H  = 2;
  localparam int SW = 16;
  localparam int FS = 2 * SW;
  localparam int F  = FS * 2 * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_ready = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          generate_next;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;

  always #5 clk = ~clk;

  sample_serializer #(.BCLK_HALF(H), .SAMPLE_WIDTH(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .generate_next (generate_next),
    .sample_ready  (sample_ready),
    .sample        (sample),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun)
  );

  // Reference: clocks since the run began, the value playing, and the latest unplayed sample.
  bit          m_run;
  bit          m_under;
  bit          m_cand_v;
  int          m_n;
  logic [SW-1:0] m_cur;
  logic [SW-1:0] m_cand;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_under = 0; m_cand_v = 0; m_n = 0; m_cur = '0; m_cand = '0;
    end else if (!m_run) begin
      m_under = 0;
      if (enable) begin
        m_run = 1; m_n = 0; m_cur = '0; m_cand_v = 0;
      end
    end else begin
      m_n++;
      m_under = 0;
      if (m_n % F == 0) begin
        if (!enable) m_run = 0;
        else begin
          if (m_cand_v) m_cur = m_cand;
          else          m_under = 1;
          m_cand_v = 0;
        end
      end
      if (m_run && sample_ready) begin
        m_cand = sample; m_cand_v = 1;
      end
    end
  end

  function automatic logic [4:0] model_outs();
    int sl;
    logic [4:0] r;
    if (!m_run) return 5'b0;
    sl   = (m_n / (2 * H)) % FS;
    r[4] = ((m_n / H) % 2) == 1;
    r[3] = sl >= SW;
    r[2] = m_cur[SW-1-(sl % SW)];
    r[1] = (m_n % F) == 0;
    r[0] = m_under;
    return r;
  endfunction

  // Sample source: answers each request after a delay, optionally skipping or randomizing.
  int          src_delay;
  bit          src_rand;
  logic [SW-1:0] src_val;
  logic [SW-1:0] spur_val;
  int          skip_req, skip_used;
  int          spur_req, spur_used;
  int          pend_cnt;
  logic [SW-1:0] pend_val;

  always @(negedge clk) begin
    sample_ready = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin sample_ready = 1'b1; sample = pend_val; end
    end
    if (spur_req != spur_used) begin
      spur_used++; sample_ready = 1'b1; sample = spur_val;
    end
    if (generate_next === 1'b1) begin
      if (skip_req != skip_used) skip_used++;
      else if (src_rand) begin
        if ($urandom_range(0, 4) != 0) begin
          pend_cnt = $urandom_range(1, F - 1);
          pend_val = SW'($urandom);
        end
      end else begin
        pend_cnt = src_delay; pend_val = src_val;
      end
    end
  end

  int vectors;
  int miscompares;
  int cyc;
  int gen_seen;
  int under_seen;
  bit chk_on;

  function automatic logic [4:0] dut_outs();
    return {bclk, lrclk, sdata, generate_next, underrun};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] e;
    logic [4:0] g;
    @(negedge clk);
    cyc++;
    if (generate_next === 1'b1) gen_seen++;
    if (underrun === 1'b1) under_seen++;
    if (chk_on) begin
      e = model_outs();
      g = dut_outs();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got{bclk,lrclk,sdata,gen,underrun}=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic wait_gen();
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (generate_next === 1'b1) found = 1;
    end
    check("wait_generate_next", {31'd0, found}, 32'd1);
  endtask

  task automatic capture(output logic [31:0] sd, output logic [31:0] lr);
    sd = '0; lr = '0;
    for (int k = 0; k < FS; k++) begin
      repeat ((k == 0) ? H : 2 * H) tick();
      sd = {sd[30:0], sdata};
      lr = {lr[30:0], lrclk};
    end
  endtask

  initial begin
    logic [31:0] sd;
    logic [31:0] lr;
    int t_a;
    int ub;
    int gb;
    vectors = 0; miscompares = 0; cyc = 0; gen_seen = 0; under_seen = 0; chk_on = 0;
    src_delay = 3; src_rand = 0; src_val = 16'h8001; spur_val = 16'h5555;
    skip_req = 0; skip_used = 0; spur_req = 0; spur_used = 0; pend_cnt = 0; pend_val = '0;
    reset = 1'b1; enable = 1'b0;
    #2 reset = 1'b0;
    chk_on = 1;
    repeat (3) tick();
    check("reset_outputs", {27'd0, dut_outs()}, 32'd0);
    reset = 1'b1; enable = 1'b1;

    wait_gen();
    t_a = cyc;
    capture(sd, lr);
    check("frame0_sdata", sd, 32'h0000_0000);
    check("frame0_lrclk", lr, 32'h0000_FFFF);
    wait_gen();
    check("frame_period", cyc - t_a, F);
    capture(sd, lr);
    check("frame1_sdata", sd, 32'h8001_8001);
    check("no_underrun_normal", under_seen, 0);

    skip_req++; src_val = 16'h1234; ub = under_seen;
    wait_gen();
    wait_gen();
    capture(sd, lr);
    check("frame3_replay", sd, 32'h8001_8001);
    check("underrun_once", under_seen - ub, 1);

    src_delay = F - 1; src_val = 16'h7FFE;
    wait_gen();
    capture(sd, lr);
    check("frame4_sdata", sd, 32'h1234_1234);
    src_val = 16'h0FF0;
    wait_gen();
    tick();
    ub = under_seen;
    wait_gen();
    capture(sd, lr);
    check("coincident_frame", sd, 32'h7FFE_7FFE);
    wait_gen();
    capture(sd, lr);
    check("coincident_next", sd, 32'h0FF0_0FF0);
    check("coincident_no_underrun", under_seen - ub, 0);

    src_rand = 1;
    repeat (6) wait_gen();

    src_rand = 0; src_delay = 3; src_val = 16'h00F0;
    wait_gen();
    repeat (10 * 2 * H + 1) tick();
    enable = 1'b0;
    gb = gen_seen;
    repeat (300) tick();
    check("no_gen_after_stop", gen_seen - gb, 0);
    check("idle_outputs", {27'd0, dut_outs()}, 32'd0);
    spur_req++;
    repeat (5) tick();

    enable = 1'b1;
    wait_gen();
    capture(sd, lr);
    check("restart_frame0", sd, 32'h0000_0000);
    wait_gen();
    repeat (20 * 2 * H + 1) tick();
    #1 reset = 1'b0;
    #1 check("async_reset_outputs", {27'd0, dut_outs()}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    wait_gen();
    capture(sd, lr);
    check("post_reset_sdata", sd, 32'h0000_0000);
    check("post_reset_lrclk", lr, 32'h0000_FFFF);

    enable = 1'b0;
    repeat (10) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 4: clk cycles per half period of bclk; legal values are 2 to 255.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16: sample width in bits; the frame carries 2*SAMPLE_WIDTH slots.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: level input; starts and stops serialization.
REQ-006 SHALL have port generate_next, output, 1 bit: one-cycle request to the sample source.
REQ-007 SHALL have port sample_ready, input, 1 bit: one-cycle strobe from the source that qualifies sample.
REQ-008 SHALL have port sample, input, SAMPLE_WIDTH bits: two's-complement sample value.
REQ-009 SHALL have port bclk, output, 1 bit: serial bit clock.
REQ-010 SHALL have port lrclk, output, 1 bit: channel select; 0 = left half, 1 = right half.
REQ-011 SHALL have port sdata, output, 1 bit: serial data, MSB-first, left-justified.
REQ-012 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame starts without a fresh sample.

Function
REQ-013 SHALL implement two states:
- IDLE: bclk, lrclk and sdata all 0.
- RUN: serializing.
REQ-014 SHALL go from IDLE to RUN on the first cycle enable=1, with bclk=0, slot=0, divider=0, and generate_next pulsed in that same cycle.
REQ-015 SHALL, in RUN, run the divider 0..BCLK_HALF-1 and toggle bclk on the cycle the divider reaches its terminal count.
REQ-016 SHALL advance slot (modulo 2*SAMPLE_WIDTH) and update sdata on every bclk high-to-low toggle, so sdata is stable at the bclk rising edge.
REQ-017 SHALL drive lrclk as the slot MSB: 0 for slots 0..SAMPLE_WIDTH-1, 1 for the remaining slots.
REQ-018 SHALL drive sdata in slot k as bit (SAMPLE_WIDTH-1-(k mod SAMPLE_WIDTH)) of the active sample; the mono sample is duplicated into both halves.
REQ-019 SHALL define frame start as the cycle slot wraps to 0; at each frame start it loads active from pending and pulses generate_next for exactly one cycle.
REQ-020 SHALL capture sample into pending whenever sample_ready=1 and set a fresh flag; frame start clears fresh.
REQ-021 SHALL, at a frame start with fresh=0, keep the previous active value and pulse underrun for one cycle.
REQ-022 SHALL treat sample_ready coincident with frame start as belonging to the next frame: pending is written, fresh ends at 1, and no underrun is raised.
REQ-023 SHALL give the following latency: the sample requested at frame N plays in frame N+1; the first frame after IDLE plays the reset value 0 and raises no underrun.
REQ-024 SHALL handle enable=0 in RUN by finishing the current frame and returning to IDLE at the next frame start, with no generate_next issued there.
REQ-025 SHALL ignore sample_ready in IDLE.

Reset
REQ-026 SHALL, while reset=0 (asynchronously, including mid-frame), force state=IDLE and zero all of the following:
- outputs: bclk, lrclk, sdata, generate_next, underrun.
- counters: divider, slot.
- registers: pending, active, fresh.
REQ-027 SHALL take effect on the first clk edge after reset release, with no pulses emitted on release itself.

Structure
REQ-028 SHALL keep the state encoding (IDLE/RUN) and the frame-length constant in the shared audio package.
REQ-029 SHALL place the bclk divider (counter plus toggle/falling-edge strobe) in one sub-module named bclk_divider.
REQ-030 SHALL use the codebase dff/dffr/dffre flop primitives for all state, with asynchronous active-low reset.

Verification
REQ-031 Reset, then enable=1 with BCLK_HALF=2 -> generate_next at cycle 0; bclk period 4 clk; frame 128 clk; next generate_next at cycle 128.
REQ-032 Source returns 0x8001 three cycles after each request -> frame 2 sdata = 1,0x14,1 in the lrclk=0 half and the same in the lrclk=1 half; underrun never asserts.
REQ-033 Source withholds sample_ready for frame 3 -> underrun pulses once at the frame 3 start; frame 3 replays the frame 2 value.
REQ-034 sample_ready forced coincident with frame start, carrying 0x7FFE -> no underrun; next frame sdata = 0,1x14,0.
REQ-035 enable dropped at slot 10 -> frame completes through slot 31; IDLE with all outputs 0; no extra generate_next.
REQ-036 reset asserted at slot 20 mid-bit -> all outputs 0 immediately (asynchronous); restart produces a clean frame from slot 0 with output value 0.
